// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI Stream packet arbiter.
// Holds the FSM state encoding and index conversion helpers.
package axis_arb_pkg;

   localparam int MAX_NIN = 16;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Index width for n sources; never narrower than one bit.
   function automatic int lgn_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Converts a one-hot vector (up to MAX_NIN bits) into its bit index.
   function automatic logic [3:0] onehot_to_idx(
      input logic [MAX_NIN-1:0] oh
   );
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_NIN; i++) begin
         if (oh[i]) idx = idx | 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker.
// Selects the first requester strictly after the pointer, wrapping.
module axis_rr_picker #(
   parameter int NIN = 4,
   parameter int LGN = 2
) (
   input  logic [NIN-1:0] req,
   input  logic [LGN-1:0] ptr,
   output logic [NIN-1:0] gnt,
   output logic [LGN-1:0] index,
   output logic           any
);

   int cand;

   // Scan the requesters in priority order starting one past the pointer.
   always_comb begin
      gnt   = '0;
      index = '0;
      any   = 1'b0;
      cand  = 0;
      for (int i = 1; i <= NIN; i++) begin
         cand = (int'(ptr) + i) % NIN;
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            index     = LGN'(cand);
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI Stream merger holding grants for whole packets.
// The master side is a fully registered output stage.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NIN = 4,
   parameter int DW = 32,
   parameter int UW = 1,
   parameter bit OPT_SKIP_IDLE_BUBBLE = 1'b0,
   localparam int LGN = lgn_of(NIN)
) (
   input  logic                  i_aclk,
   input  logic                  i_aresetn,
   input  logic [NIN-1:0]        s_axis_tvalid,
   output logic [NIN-1:0]        s_axis_tready,
   input  logic [NIN*DW-1:0]     s_axis_tdata,
   input  logic [NIN*DW/8-1:0]   s_axis_tkeep,
   input  logic [NIN-1:0]        s_axis_tlast,
   input  logic [NIN*UW-1:0]     s_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DW-1:0]         m_axis_tdata,
   output logic [DW/8-1:0]       m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic [LGN-1:0]        m_axis_tid,
   output logic [UW-1:0]         m_axis_tuser,
   output logic [NIN-1:0]        o_grant,
   output logic                  o_busy
);

   localparam int KW = DW / 8;

   state_t         state_q, state_d;
   logic [LGN-1:0] ptr_q, ptr_d;
   logic [NIN-1:0] grant_q, grant_d;
   logic           mv_q, mv_d;
   logic [DW-1:0]  data_q, data_d;
   logic [KW-1:0]  keep_q, keep_d;
   logic           last_q, last_d;
   logic [LGN-1:0] tid_q, tid_d;
   logic [UW-1:0]  user_q, user_d;

   logic [NIN-1:0] pk_gnt;
   logic [LGN-1:0] pk_idx;
   logic           pk_any;

   logic [LGN-1:0] gidx;
   int             gi;
   logic           out_ready;
   logic           sel_valid;
   logic           sel_last;
   logic [DW-1:0]  sel_data;
   logic [KW-1:0]  sel_keep;
   logic [UW-1:0]  sel_user;
   logic           accept;

   axis_rr_picker #(
      .NIN (NIN),
      .LGN (LGN)
   ) u_picker (
      .req   (s_axis_tvalid),
      .ptr   (ptr_q),
      .gnt   (pk_gnt),
      .index (pk_idx),
      .any   (pk_any)
   );

   assign gidx = LGN'(onehot_to_idx(MAX_NIN'(grant_q)));
   assign gi   = int'(gidx);

   // Route the granted source to the output stage and gate its ready.
   always_comb begin
      out_ready     = !mv_q || m_axis_tready;
      sel_valid     = s_axis_tvalid[gi];
      sel_last      = s_axis_tlast[gi];
      sel_data      = s_axis_tdata[gi*DW +: DW];
      sel_keep      = s_axis_tkeep[gi*KW +: KW];
      sel_user      = s_axis_tuser[gi*UW +: UW];
      accept        = (state_q == BUSY) && sel_valid && out_ready;
      s_axis_tready = '0;
      if (state_q == BUSY && out_ready) s_axis_tready = grant_q;
   end

   // Next state, grant, pointer and output-register contents.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      mv_d    = mv_q && !m_axis_tready;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      tid_d   = tid_q;
      user_d  = user_q;
      unique case (state_q)
         IDLE: begin
            if (pk_any) begin
               grant_d = pk_gnt;
               ptr_d   = pk_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               mv_d   = 1'b1;
               data_d = sel_data;
               keep_d = sel_keep;
               last_d = sel_last;
               tid_d  = gidx;
               user_d = sel_user;
               if (sel_last) begin
                  if (OPT_SKIP_IDLE_BUBBLE && pk_any) begin
                     grant_d = pk_gnt;
                     ptr_d   = pk_idx;
                  end else begin
                     grant_d = '0;
                     state_d = IDLE;
                  end
               end
            end
         end
      endcase
   end

   // State and output registers; reset drops any in-flight beat.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= IDLE;
         ptr_q   <= LGN'(NIN - 1);
         grant_q <= '0;
         mv_q    <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         tid_q   <= '0;
         user_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         mv_q    <= mv_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         tid_q   <= tid_d;
         user_q  <= user_d;
      end
   end

   assign m_axis_tvalid = mv_q;
   assign m_axis_tdata  = data_q;
   assign m_axis_tkeep  = keep_q;
   assign m_axis_tlast  = last_q;
   assign m_axis_tid    = tid_q;
   assign m_axis_tuser  = user_q;
   assign o_grant       = grant_q;
   assign o_busy        = (state_q == BUSY) || mv_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter.
// Directed table, hand sequences and randomized traffic vs a packet model.
module tb_axis_packet_arbiter;

   localparam int NIN = 4;
   localparam int DW  = 32;
   localparam int UW  = 1;
   localparam int KW  = DW / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NIN-1:0]    s_tvalid, s_tready, s_tlast;
   logic [NIN*DW-1:0] s_tdata;
   logic [NIN*KW-1:0] s_tkeep;
   logic [NIN*UW-1:0] s_tuser;
   logic              m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tkeep;
   logic [1:0]        m_tid;
   logic [UW-1:0]     m_tuser;
   logic [NIN-1:0]    o_grant;
   logic              o_busy;

   logic [NIN-1:0]    b_tvalid, b_tready, b_tlast;
   logic [NIN*DW-1:0] b_tdata;
   logic [NIN*KW-1:0] b_tkeep;
   logic [NIN*UW-1:0] b_tuser;
   logic              bm_tvalid, bm_tready, bm_tlast;
   logic [DW-1:0]     bm_tdata;
   logic [KW-1:0]     bm_tkeep;
   logic [1:0]        bm_tid;
   logic [UW-1:0]     bm_tuser;
   logic [NIN-1:0]    b_grant;
   logic              b_busy;

   axis_packet_arbiter #(
      .NIN(NIN), .DW(DW), .UW(UW), .OPT_SKIP_IDLE_BUBBLE(1'b0)
   ) dut (
      .i_aclk(clk), .i_aresetn(rst_n),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
      .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
      .m_axis_tuser(m_tuser), .o_grant(o_grant), .o_busy(o_busy)
   );

   axis_packet_arbiter #(
      .NIN(NIN), .DW(DW), .UW(UW), .OPT_SKIP_IDLE_BUBBLE(1'b1)
   ) dut_b (
      .i_aclk(clk), .i_aresetn(rst_n),
      .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
      .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep),
      .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
      .m_axis_tvalid(bm_tvalid), .m_axis_tready(bm_tready),
      .m_axis_tdata(bm_tdata), .m_axis_tkeep(bm_tkeep),
      .m_axis_tlast(bm_tlast), .m_axis_tid(bm_tid),
      .m_axis_tuser(bm_tuser), .o_grant(b_grant), .o_busy(b_busy)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct {
      int          tid;
      logic [31:0] data;
      int          cyc;
   } olog_t;

   typedef struct {
      logic [NIN-1:0] vld;
      logic [31:0]    data;
      logic           last;
      logic           rdy;
      logic [NIN-1:0] e_sr;
      logic [NIN-1:0] e_gnt;
      logic           e_mv;
      logic [31:0]    e_data;
      logic [1:0]     e_tid;
      logic           e_last;
      logic           e_busy;
   } vec_t;

   beat_t          srcq[NIN][$];
   beat_t          expq[NIN][$];
   olog_t          olog[$];
   logic [NIN-1:0] holding;
   logic [NIN-1:0] src_en;
   int             p_valid, p_ready;
   int             mptr, cur_src, cyc;
   int             n_cmp = 0;
   int             n_fail = 0;
   vec_t           tv[12];

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic int rr(input logic [NIN-1:0] v, input int p);
      for (int i = 1; i <= NIN; i++)
         if (v[(p + i) % NIN]) return (p + i) % NIN;
      return 0;
   endfunction

   function automatic vec_t mk(
      input logic [3:0] vld, input logic [31:0] d, input logic l,
      input logic r, input logic [3:0] esr, input logic [3:0] eg,
      input logic emv, input logic [31:0] ed, input logic [1:0] et,
      input logic el, input logic eb);
      vec_t v;
      v.vld = vld; v.data = d; v.last = l; v.rdy = r;
      v.e_sr = esr; v.e_gnt = eg; v.e_mv = emv; v.e_data = ed;
      v.e_tid = et; v.e_last = el; v.e_busy = eb;
      return v;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;
      s_tkeep = '0; s_tuser = '0; m_tready = 1'b0;
      b_tvalid = '0; b_tlast = '0; b_tdata = '0;
      b_tkeep = '0; b_tuser = '0; bm_tready = 1'b0;
      #1;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_fields", {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid}, 0);
      chk("rst_o_grant", o_grant, 0);
      chk("rst_o_busy", o_busy, 0);
      chk("rst_s_tready", s_tready, 0);
      mptr = NIN - 1;
      cur_src = -1;
      holding = '0;
      src_en = '1;
      for (int k = 0; k < NIN; k++) begin
         srcq[k].delete();
         expq[k].delete();
      end
      olog.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step();
      logic [NIN-1:0] sv, sr, pg, acc, eg, esr;
      logic           pmv, pmr, emv;
      logic [1:0]     ptid, etid;
      beat_t          pb, accb, eb, ob;
      int             g, p;
      accb = '0;
      eb = '0;
      etid = '0;
      for (int k = 0; k < NIN; k++) begin
         if (!src_en[k] || srcq[k].size() == 0) holding[k] = 1'b0;
         else if (!holding[k] && $urandom_range(0, 99) < p_valid)
            holding[k] = 1'b1;
         s_tvalid[k] = holding[k];
         if (srcq[k].size() > 0) begin
            s_tdata[k*DW +: DW] = srcq[k][0].data;
            s_tkeep[k*KW +: KW] = srcq[k][0].keep;
            s_tlast[k] = srcq[k][0].last;
            s_tuser[k] = srcq[k][0].user;
         end
      end
      m_tready = ($urandom_range(0, 99) < p_ready);
      #4;
      sv = s_tvalid; sr = s_tready; pg = o_grant;
      pmv = m_tvalid; pmr = m_tready; ptid = m_tid;
      pb = {m_tdata, m_tkeep, m_tlast, m_tuser};
      esr = (pg != 0 && (!pmv || pmr)) ? pg : '0;
      chk("s_tready", sr, esr);
      if (pmv && pmr) begin
         if (expq[ptid].size() == 0) fail_now("out_beat_unexpected");
         else begin
            ob = expq[ptid].pop_front();
            chk("out_beat", pb, ob);
         end
         if (cur_src >= 0) chk("no_interleave", ptid, cur_src);
         cur_src = pb.last ? -1 : int'(ptid);
         olog.push_back('{tid: int'(ptid), data: pb.data, cyc: cyc});
      end
      g = -1;
      for (int k = 0; k < NIN; k++) if (pg[k]) g = k;
      acc = sv & sr;
      for (int k = 0; k < NIN; k++) begin
         if (acc[k]) begin
            accb = srcq[k].pop_front();
            expq[k].push_back(accb);
            holding[k] = 1'b0;
         end
      end
      @(negedge clk);
      cyc++;
      if (g < 0) begin
         if (sv != 0) begin
            p = rr(sv, mptr);
            eg = '0;
            eg[p] = 1'b1;
            mptr = p;
         end else eg = '0;
      end else if (acc[g] && accb.last) eg = '0;
      else eg = pg;
      chk("o_grant", o_grant, eg);
      if (acc != 0) begin
         emv = 1'b1; eb = accb; etid = 2'(g);
      end else if (pmv && !pmr) begin
         emv = 1'b1; eb = pb; etid = ptid;
      end else emv = 1'b0;
      chk("m_tvalid", m_tvalid, emv);
      if (emv)
         chk("m_fields", {m_tdata, m_tkeep, m_tlast, m_tuser, m_tid},
             {eb, etid});
      chk("o_busy", o_busy, (eg != 0) || emv);
   endtask

   function automatic bit pending();
      bit r;
      r = m_tvalid;
      for (int k = 0; k < NIN; k++)
         if (srcq[k].size() != 0 || expq[k].size() != 0) r = 1'b1;
      return r;
   endfunction

   task automatic drain(input int budget, input string name);
      int n;
      n = 0;
      while (pending() && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) fail_now({name, "_timeout"});
   endtask

   task automatic push_pkt(input int k, input int len, input int tag);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = 32'(tag * 16 + i);
         b.keep = 4'hF;
         b.last = (i == len - 1);
         b.user = 1'(i);
         srcq[k].push_back(b);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      rst_n = 1'b1;
      #1;
      do_reset();

      tv[0]  = mk(4'b0100, 32'hA0, 0, 1, 4'b0000, 4'b0100, 0, 0, 0, 0, 1);
      tv[1]  = mk(4'b0100, 32'hA0, 0, 1, 4'b0100, 4'b0100, 1, 32'hA0, 2, 0, 1);
      tv[2]  = mk(4'b0100, 32'hA1, 0, 1, 4'b0100, 4'b0100, 1, 32'hA1, 2, 0, 1);
      tv[3]  = mk(4'b0100, 32'hA2, 1, 1, 4'b0100, 4'b0000, 1, 32'hA2, 2, 1, 1);
      tv[4]  = mk(4'b0000, 32'h00, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
      tv[5]  = mk(4'b0010, 32'hB0, 0, 1, 4'b0000, 4'b0010, 0, 0, 0, 0, 1);
      tv[6]  = mk(4'b0010, 32'hB0, 0, 1, 4'b0010, 4'b0010, 1, 32'hB0, 1, 0, 1);
      tv[7]  = mk(4'b0010, 32'hB1, 1, 0, 4'b0000, 4'b0010, 1, 32'hB0, 1, 0, 1);
      tv[8]  = mk(4'b0010, 32'hB1, 1, 0, 4'b0000, 4'b0010, 1, 32'hB0, 1, 0, 1);
      tv[9]  = mk(4'b0010, 32'hB1, 1, 1, 4'b0010, 4'b0000, 1, 32'hB1, 1, 1, 1);
      tv[10] = mk(4'b0000, 32'h00, 0, 0, 4'b0000, 4'b0000, 1, 32'hB1, 1, 1, 1);
      tv[11] = mk(4'b0000, 32'h00, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);

      for (int i = 0; i < 12; i++) begin
         s_tvalid = tv[i].vld;
         s_tdata = {NIN{tv[i].data}};
         s_tkeep = '1;
         s_tuser = '0;
         s_tlast = {NIN{tv[i].last}};
         m_tready = tv[i].rdy;
         #4;
         chk($sformatf("tv%0d_s_tready", i), s_tready, tv[i].e_sr);
         @(negedge clk);
         cyc++;
         chk($sformatf("tv%0d_grant", i), o_grant, tv[i].e_gnt);
         chk($sformatf("tv%0d_mvalid", i), m_tvalid, tv[i].e_mv);
         chk($sformatf("tv%0d_busy", i), o_busy, tv[i].e_busy);
         if (tv[i].e_mv)
            chk($sformatf("tv%0d_beat", i), {m_tdata, m_tid, m_tlast},
                {tv[i].e_data, tv[i].e_tid, tv[i].e_last});
      end

      do_reset();
      p_valid = 100;
      p_ready = 100;
      for (int k = 0; k < NIN; k++) push_pkt(k, 2, k + 1);
      drain(100, "fair");
      chk("fair_count", olog.size(), 8);
      for (int i = 0; i < olog.size() && i < 8; i++) begin
         chk($sformatf("fair_tid%0d", i), olog[i].tid, i / 2);
         if (i > 0)
            chk($sformatf("fair_gap%0d", i), olog[i].cyc - olog[i-1].cyc,
                (i % 2 == 1) ? 1 : 2);
      end

      do_reset();
      push_pkt(0, 4, 7);
      push_pkt(3, 2, 9);
      src_en = 4'b0001;
      step();
      step();
      src_en = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("gap_hold_grant", o_grant, 4'b0001);
      end
      src_en = '1;
      drain(100, "gap");
      chk("gap_count", olog.size(), 6);
      for (int i = 0; i < olog.size() && i < 6; i++)
         chk($sformatf("gap_tid%0d", i), olog[i].tid, (i < 4) ? 0 : 3);

      do_reset();
      push_pkt(2, 4, 3);
      p_ready = 0;
      step();
      step();
      step();
      chk("midrst_mvalid_pre", m_tvalid, 1);
      #2;
      do_reset();
      p_ready = 100;
      push_pkt(0, 1, 4);
      push_pkt(3, 1, 5);
      drain(100, "midrst");
      chk("midrst_count", olog.size(), 2);
      if (olog.size() > 0) chk("midrst_first", olog[0].tid, 0);

      do_reset();
      p_valid = 60;
      p_ready = 70;
      for (int k = 0; k < NIN; k++)
         for (int j = 0; j < 6; j++)
            begin
               beat_t b;
               int len;
               len = $urandom_range(1, 4);
               for (int i = 0; i < len; i++) begin
                  b.data = $urandom;
                  b.keep = 4'($urandom);
                  b.user = 1'($urandom);
                  b.last = (i == len - 1);
                  srcq[k].push_back(b);
               end
            end
      drain(4000, "random");

      do_reset();
      b_tvalid = 4'b0011;
      b_tlast = '1;
      b_tkeep = '1;
      b_tdata = {32'h103, 32'h102, 32'h101, 32'h100};
      bm_tready = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         cyc++;
         if (n >= 2) begin
            chk($sformatf("skip_mvalid%0d", n), bm_tvalid, 1);
            chk($sformatf("skip_tid%0d", n), bm_tid, n % 2);
            chk($sformatf("skip_data%0d", n), bm_tdata, 32'h100 + n % 2);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
Round-robin arbiter that merges NIN AXI Stream sources onto one AXI Stream master port. Grants are held for whole packets: a grant is taken at packet start and released only after the granted source's TLAST beat is accepted. The output port is fully registered and compliant with the AXI Stream master handshake rules, so no payload field changes while TVALID && !TREADY. The block sits upstream of shared stream sinks such as DMA write engines and width converters.

Parameters:
NIN, 4, number of source ports (2..16)
DW, 32, TDATA width in bits (multiple of 8)
UW, 1, TUSER width in bits
LGN, $clog2(NIN), index width; derived, not overridable
OPT_SKIP_IDLE_BUBBLE, 0, if 1, a new grant may start in the same cycle the previous TLAST is accepted

Ports:
i_aclk  in  1  clock
i_aresetn  in  1  asynchronous active-low reset
s_axis_tvalid  in  NIN  per-source TVALID
s_axis_tready  out  NIN  per-source TREADY
s_axis_tdata  in  NIN*DW  packed per-source TDATA, source k at [k*DW +: DW]
s_axis_tkeep  in  NIN*DW/8  packed TKEEP
s_axis_tlast  in  NIN  per-source TLAST
s_axis_tuser  in  NIN*UW  packed TUSER
m_axis_tvalid  out  1  merged TVALID (registered)
m_axis_tready  in  1  downstream TREADY
m_axis_tdata  out  DW  merged TDATA (registered)
m_axis_tkeep  out  DW/8  merged TKEEP (registered)
m_axis_tlast  out  1  merged TLAST (registered)
m_axis_tid  out  LGN  index of the source that produced the beat (registered)
m_axis_tuser  out  UW  merged TUSER (registered)
o_grant  out  NIN  one-hot current grant; zero when idle
o_busy  out  1  a packet is in progress

Behaviour:
- Reset (asynchronous, i_aresetn low): m_axis_tvalid=0, all other m_axis_* fields=0, o_grant=0, o_busy=0, s_axis_tready=0, state=IDLE, priority pointer=NIN-1 (so source 0 wins first).
- The first cycle after reset deassertion behaves as IDLE; no beat is accepted in that cycle.
- FSM states:
  - IDLE: if any s_axis_tvalid is high, pick the first requester strictly after the pointer, modulo NIN. Register the one-hot o_grant, set the pointer to that index, go to BUSY. Grant latency is 1 cycle. s_axis_tready is 0 in IDLE.
  - BUSY: s_axis_tready[g] = !m_axis_tvalid || m_axis_tready. All other s_axis_tready bits are 0.
  - BUSY accept (s_axis_tvalid[g] && s_axis_tready[g]): register the selected beat into the m_axis_* fields, set m_axis_tid=g, set m_axis_tvalid=1.
  - BUSY exit: when the accepted beat has tlast=1, go to IDLE and clear o_grant in the next cycle.
  - If OPT_SKIP_IDLE_BUBBLE=1, re-arbitrate in that same cycle instead of going to IDLE; requesters considered exclude nothing, and pointer order still applies.
- Output register:
  - m_axis_tvalid clears on m_axis_tready when no new beat is accepted in the same cycle.
  - Simultaneous drain and accept is a full-throughput handoff: in BUSY, one beat per cycle is sustained.
  - While m_axis_tvalid && !m_axis_tready, all m_axis_* fields are held stable.
- Source gaps: a granted source may drop tvalid mid-packet. The grant is held indefinitely; there is no timeout.
- Only the granted source is ever stalled or accepted. Non-granted tvalid is ignored.
- Fairness: with all NIN sources requesting continuously, grants rotate 0,1,…,NIN-1,0…
- A single-beat packet (tlast on the first beat) is a legal packet. It is granted and released like any other.
- o_busy = (state==BUSY) || m_axis_tvalid.
- Reset mid-packet: the output beat is dropped and m_axis_tvalid falls asynchronously. Recovering partial-packet framing is the upstream's responsibility.

Decomposition:
- Package axis_arb_pkg: state enum (IDLE, BUSY), LGN computation function, one-hot-to-index function.
- Sub-module axis_rr_picker: purely combinational round-robin picker.
  - Inputs: req[NIN], pointer[LGN].
  - Outputs: one-hot gnt[NIN], index[LGN], any.
  - Instantiated once, so it can be unit-tested alone.
- Formal: bind an AXI Stream slave property checker to each s_axis port and the matching master checker to m_axis.

Test Plan:
1. Reset, then source 2 sends a 3-beat packet (tdata 0xA0,0xA1,0xA2, tlast on 0xA2) with m_axis_tready=1 -> o_grant=0100 one cycle after tvalid; m_axis_tid=2; 3 consecutive output beats; o_grant=0 after tlast.
2. All 4 sources each hold a 2-beat packet, m_axis_tready=1 -> output order src0,src1,src2,src3; m_axis_tid sequence 0,0,1,1,2,2,3,3; one idle bubble between packets (OPT_SKIP_IDLE_BUBBLE=0).
3. Source 1 active, m_axis_tready toggles 1,0,0,1 -> m_axis_* fields stable during the stall; s_axis_tready[1]=0 while output is full and stalled; no beat lost or duplicated.
4. Source 0 mid-packet drops tvalid for 5 cycles while source 3 requests -> grant stays 0001; source 3 is served only after source 0's tlast.
5. Assert i_aresetn=0 mid-packet with m_axis_tvalid=1 -> m_axis_tvalid=0 and o_grant=0 immediately; after release, source 0 wins first.
6. OPT_SKIP_IDLE_BUBBLE=1, sources 0 and 1 continuous single-beat packets -> output beats every cycle alternating tid 0,1,0,1.
